// File: rtl/mask_bbox_tracker_if.sv
// mask_bbox_tracker_if: pixel-mask sample stream in, per-frame bounding-box result out
// Pixel side: valid_in, hcount_in, vcount_in, mask_in.
// Result side: result_valid_out/result_ready_in handshake carrying x/y min/max,
// count_out, empty_out and the sticky overrun_out flag.
interface mask_bbox_tracker_if #(
   parameter int HW = 9,
   parameter int VW = 8,
   parameter int CW = 17
);
   logic          valid_in;
   logic [HW-1:0] hcount_in;
   logic [VW-1:0] vcount_in;
   logic          mask_in;
   logic          result_valid_out;
   logic          result_ready_in;
   logic [HW-1:0] x_min_out;
   logic [HW-1:0] x_max_out;
   logic [VW-1:0] y_min_out;
   logic [VW-1:0] y_max_out;
   logic [CW-1:0] count_out;
   logic          empty_out;
   logic          overrun_out;
   modport slave (
      input  valid_in, hcount_in, vcount_in, mask_in, result_ready_in,
      output result_valid_out, x_min_out, x_max_out, y_min_out, y_max_out,
             count_out, empty_out, overrun_out
   );
   modport master (
      output valid_in, hcount_in, vcount_in, mask_in, result_ready_in,
      input  result_valid_out, x_min_out, x_max_out, y_min_out, y_max_out,
             count_out, empty_out, overrun_out
   );
endinterface

// File: rtl/mask_bbox_tracker.sv
// mask_bbox_tracker: per-frame bounding box and population count of set mask pixels
// Ports: clk_in, rst_n_in (async assert, active-low), bus (slave side of
// mask_bbox_tracker_if: pixel samples in, frame result out via valid/ready).
module mask_bbox_tracker #(
   parameter int H_ACTIVE = 320,
   parameter int V_ACTIVE = 240,
   parameter int HW       = 9,
   parameter int VW       = 8,
   parameter int CW       = 17
) (
   input logic clk_in,
   input logic rst_n_in,
   mask_bbox_tracker_if.slave bus
);
   typedef enum logic {IDLE, FULL} state_t;
   localparam logic [HW-1:0] X_LAST = HW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] Y_LAST = VW'(V_ACTIVE - 1);
   state_t        state_q, state_d;
   logic          hit_q, hit_d, empty_q, empty_d, overrun_q, overrun_d;
   logic [HW-1:0] ax_min_q, ax_min_d, ax_max_q, ax_max_d, x_min_q, x_min_d, x_max_q, x_max_d;
   logic [VW-1:0] ay_min_q, ay_min_d, ay_max_q, ay_max_d, y_min_q, y_min_d, y_max_q, y_max_d;
   logic [CW-1:0] acnt_q, acnt_d, count_q, count_d;
   logic          in_range, sof, eof, pix, hit_b, xfer, a_hit;
   logic [HW-1:0] a_xmin, a_xmax;
   logic [VW-1:0] a_ymin, a_ymax;
   logic [CW-1:0] a_cnt;
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   assign h        = bus.hcount_in;
   assign v        = bus.vcount_in;
   assign in_range = bus.valid_in && h <= X_LAST && v <= Y_LAST;
   assign sof      = in_range && h == '0 && v == '0;
   assign eof      = in_range && h == X_LAST && v == Y_LAST;
   assign pix      = in_range && bus.mask_in;
   // A frame-start sample discards whatever partial frame was in progress
   assign hit_b    = hit_q && !sof;
   assign xfer     = state_q == FULL && bus.result_ready_in;
   always_comb begin
      // Totals including the current sample; the frame-end sample uses these directly
      a_hit     = hit_b | pix;
      a_xmin    = !pix ? ax_min_q : (!hit_b || h < ax_min_q) ? h : ax_min_q;
      a_xmax    = !pix ? ax_max_q : (!hit_b || h > ax_max_q) ? h : ax_max_q;
      a_ymin    = !pix ? ay_min_q : (!hit_b || v < ay_min_q) ? v : ay_min_q;
      a_ymax    = !pix ? ay_max_q : (!hit_b || v > ay_max_q) ? v : ay_max_q;
      a_cnt     = !pix ? (hit_b ? acnt_q : '0) : !hit_b ? CW'(1) : acnt_q + CW'(!(&acnt_q));
      hit_d     = eof ? 1'b0 : a_hit;
      ax_min_d  = eof ? '0 : a_xmin;
      ax_max_d  = eof ? '0 : a_xmax;
      ay_min_d  = eof ? '0 : a_ymin;
      ay_max_d  = eof ? '0 : a_ymax;
      acnt_d    = eof ? '0 : a_cnt;
      x_min_d   = eof ? (a_hit ? a_xmin : '0) : x_min_q;
      x_max_d   = eof ? (a_hit ? a_xmax : '0) : x_max_q;
      y_min_d   = eof ? (a_hit ? a_ymin : '0) : y_min_q;
      y_max_d   = eof ? (a_hit ? a_ymax : '0) : y_max_q;
      count_d   = eof ? (a_hit ? a_cnt : '0) : count_q;
      empty_d   = eof ? !a_hit : empty_q;
      state_d   = eof ? FULL : xfer ? IDLE : state_q;
      // Overwriting an unaccepted result is lost data; a coincident transfer is not
      overrun_d = overrun_q | (eof && state_q == FULL && !bus.result_ready_in);
   end
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         hit_q     <= 1'b0;
         ax_min_q  <= '0;
         ax_max_q  <= '0;
         ay_min_q  <= '0;
         ay_max_q  <= '0;
         acnt_q    <= '0;
         x_min_q   <= '0;
         x_max_q   <= '0;
         y_min_q   <= '0;
         y_max_q   <= '0;
         count_q   <= '0;
         empty_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hit_q     <= hit_d;
         ax_min_q  <= ax_min_d;
         ax_max_q  <= ax_max_d;
         ay_min_q  <= ay_min_d;
         ay_max_q  <= ay_max_d;
         acnt_q    <= acnt_d;
         x_min_q   <= x_min_d;
         x_max_q   <= x_max_d;
         y_min_q   <= y_min_d;
         y_max_q   <= y_max_d;
         count_q   <= count_d;
         empty_q   <= empty_d;
         overrun_q <= overrun_d;
      end
   end
   assign bus.result_valid_out = state_q == FULL;
   assign bus.x_min_out        = x_min_q;
   assign bus.x_max_out        = x_max_q;
   assign bus.y_min_out        = y_min_q;
   assign bus.y_max_out        = y_max_q;
   assign bus.count_out        = count_q;
   assign bus.empty_out        = empty_q;
   assign bus.overrun_out      = overrun_q;
endmodule

// File: tb/tb_mask_bbox_tracker.sv
// tb_mask_bbox_tracker: directed checks of mask_bbox_tracker on an 8x4 frame
module tb_mask_bbox_tracker;
   localparam int HW = 9;
   localparam int VW = 8;
   localparam int CW = 17;
   localparam logic [31:0] M_A  = 32'h0008_2400;
   localparam logic [31:0] M_S  = 32'h8000_0000;
   localparam logic [31:0] M_F  = 32'h4000_0010;
   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   mask_bbox_tracker_if #(.HW(HW), .VW(VW), .CW(CW)) bus ();
   mask_bbox_tracker #(.H_ACTIVE(8), .V_ACTIVE(4), .HW(HW), .VW(VW), .CW(CW)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic send(input int h, input int v, input logic m);
      @(negedge clk);
      bus.valid_in  = 1'b1;
      bus.hcount_in = HW'(h);
      bus.vcount_in = VW'(v);
      bus.mask_in   = m;
   endtask
   task automatic idle();
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.mask_in  = 1'b0;
   endtask
   task automatic rows(input logic [31:0] m, input int v0, input int v1);
      for (int v = v0; v <= v1; v++)
         for (int h = 0; h < 8; h++)
            send(h, v, m[v*8+h]);
   endtask
   task automatic chk_res(input string tag, input int xmn, input int xmx, input int ymn,
                          input int ymx, input int cnt, input int emp);
      chk({tag, "_x_min"}, 32'(bus.x_min_out), xmn);
      chk({tag, "_x_max"}, 32'(bus.x_max_out), xmx);
      chk({tag, "_y_min"}, 32'(bus.y_min_out), ymn);
      chk({tag, "_y_max"}, 32'(bus.y_max_out), ymx);
      chk({tag, "_count"}, 32'(bus.count_out), cnt);
      chk({tag, "_empty"}, 32'(bus.empty_out), emp);
   endtask
   initial begin
      rst_n = 1'b1;
      bus.valid_in = 1'b0;
      bus.hcount_in = '0;
      bus.vcount_in = '0;
      bus.mask_in = 1'b0;
      bus.result_ready_in = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_valid", 32'(bus.result_valid_out), 0);
      chk("rst_overrun", 32'(bus.overrun_out), 0);
      chk_res("rst", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      // basic frame, ready tied high: one-cycle valid pulse
      rows(M_A, 0, 3);
      idle();
      chk("a_valid", 32'(bus.result_valid_out), 1);
      chk_res("a", 2, 5, 1, 2, 3, 0);
      idle();
      chk("a_valid_drop", 32'(bus.result_valid_out), 0);
      // all-zero mask
      rows(32'h0, 0, 3);
      idle();
      chk("e_valid", 32'(bus.result_valid_out), 1);
      chk_res("e", 0, 0, 0, 0, 0, 1);
      // single hit on the frame-end pixel, with out-of-range samples mixed in
      rows(M_S, 0, 1);
      send(9, 1, 1'b1);
      send(2, 7, 1'b1);
      send(0, 5, 1'b1);
      rows(M_S, 2, 3);
      idle();
      chk("s_valid", 32'(bus.result_valid_out), 1);
      chk_res("s", 7, 7, 3, 3, 1, 0);
      // backpressure across two frames
      idle();
      bus.result_ready_in = 1'b0;
      rows(M_A, 0, 3);
      idle();
      chk("bp1_valid", 32'(bus.result_valid_out), 1);
      chk("bp1_overrun", 32'(bus.overrun_out), 0);
      chk_res("bp1", 2, 5, 1, 2, 3, 0);
      idle();
      idle();
      idle();
      rows(M_S, 0, 2);
      chk("bp_hold_valid", 32'(bus.result_valid_out), 1);
      chk("bp_hold_overrun", 32'(bus.overrun_out), 0);
      chk_res("bp_hold", 2, 5, 1, 2, 3, 0);
      rows(M_S, 3, 3);
      idle();
      chk("bp2_valid", 32'(bus.result_valid_out), 1);
      chk("bp2_overrun", 32'(bus.overrun_out), 1);
      chk_res("bp2", 7, 7, 3, 3, 1, 0);
      @(negedge clk);
      bus.result_ready_in = 1'b1;
      @(negedge clk);
      chk("bp_drop_valid", 32'(bus.result_valid_out), 0);
      chk("bp_drop_overrun", 32'(bus.overrun_out), 1);
      // partial frame discarded by restart
      send(1, 0, 1'b1);
      send(2, 0, 1'b0);
      idle();
      idle();
      chk("p_no_result", 32'(bus.result_valid_out), 0);
      rows(32'h0, 0, 3);
      idle();
      chk("p_valid", 32'(bus.result_valid_out), 1);
      chk_res("p", 0, 0, 0, 0, 0, 1);
      // async reset mid-frame while a result is pending
      idle();
      bus.result_ready_in = 1'b0;
      rows(M_A, 0, 3);
      idle();
      chk("r_pre_valid", 32'(bus.result_valid_out), 1);
      rows(M_A, 0, 1);
      @(negedge clk);
      bus.valid_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("r_valid", 32'(bus.result_valid_out), 0);
      chk("r_overrun", 32'(bus.overrun_out), 0);
      chk_res("r", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.result_ready_in = 1'b1;
      rows(M_F, 0, 3);
      idle();
      chk("f_valid", 32'(bus.result_valid_out), 1);
      chk("f_overrun", 32'(bus.overrun_out), 0);
      chk_res("f", 4, 6, 0, 3, 2, 0);
      idle();
      chk("f_valid_drop", 32'(bus.result_valid_out), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mask_bbox_tracker.md
Name: mask_bbox_tracker

Overview:
Consumer of the 1-bit pixel mask stream from the threshold stage. Per frame, accumulates the bounding box (min/max x, min/y) and the population count of set mask pixels. At the end of each frame, publishes the result through a valid/ready handshake to the downstream overlay/centroid logic. Sits directly after the threshold stage in the camera pipeline. The caller aligns coordinates with the mask, so it compensates the threshold stage's 1-cycle latency.

Parameters:
H_ACTIVE, 320, active pixels per line.
V_ACTIVE, 240, active lines per frame.
HW, 9, width of x coordinate (≥ clog2(H_ACTIVE)).
VW, 8, width of y coordinate (≥ clog2(V_ACTIVE)).
CW, 17, width of pixel count (≥ clog2(H_ACTIVE*V_ACTIVE+1)).

Ports:
clk_in  input  1  system clock.
rst_n_in  input  1  reset, asynchronous assert, active-low.
valid_in  input  1  pixel sample valid this cycle.
hcount_in  input  HW  x coordinate of sample.
vcount_in  input  VW  y coordinate of sample.
mask_in  input  1  threshold result for sample.
result_valid_out  output  1  frame result available.
result_ready_in  input  1  downstream accepts result.
x_min_out  output  HW  leftmost set pixel.
x_max_out  output  HW  rightmost set pixel.
y_min_out  output  VW  topmost set pixel.
y_max_out  output  VW  bottommost set pixel.
count_out  output  CW  number of set pixels in frame.
empty_out  output  1  frame contained no set pixels.
overrun_out  output  1  sticky: a result was overwritten before acceptance.

Behaviour:
- Reset (rst_n_in low, async): all outputs 0, accumulators cleared, hit flag 0. Leaving reset is synchronous to clk_in.
- Sampling: act only when valid_in=1. Samples with hcount_in≥H_ACTIVE or vcount_in≥V_ACTIVE are ignored entirely, including for frame-end detection.
- Accumulate: on a valid in-range sample with mask_in=1:
  - If the hit flag is 0, set min=max=sample coordinate and count=1. Set the hit flag.
  - Otherwise update min/max by unsigned compare and increment count.
  - Count saturates at all-ones; it is unreachable with legal parameters.
- Frame start resync: a valid sample at (0,0) reinitialises the accumulators before accumulating that sample. Any partial frame in progress is discarded silently, with no result.
- Frame end: a valid sample at (H_ACTIVE-1, V_ACTIVE-1) is accumulated first. Its final totals are then latched into the output registers at that same clock edge.
  - result_valid_out=1 from the next cycle (1-cycle latency).
  - Accumulators reinit at the same edge, so the next sample begins a new frame.
- Empty frame: empty_out=1, count_out=0, bbox outputs 0.
- Handshake: the result holds stable while result_valid_out=1 and result_ready_in=0. A transfer occurs on a cycle with both high; result_valid_out falls the next cycle. result_ready_in is ignored while result_valid_out=0.
- Simultaneous frame end and transfer: the new result loads and result_valid_out stays 1. This is not an overrun.
- Frame end while result_valid_out=1 and result_ready_in=0: the new result overwrites the old one and overrun_out is set. overrun_out clears only on reset.
- FSM with 2 states on the output side:
  - IDLE → FULL on frame end.
  - FULL → IDLE on transfer without a coincident frame end.
  - FULL → FULL on frame end.
- The accumulator side is the flat datapath above, with no backpressure to the pixel stream; it never stalls.

Test Plan:
Use H_ACTIVE=8, V_ACTIVE=4 for all scenarios.
- Full frame, mask set at (2,1),(5,1),(3,2), ready tied 1 → one-cycle result_valid_out pulse the cycle after (7,3). Result: x_min=2, x_max=5, y_min=1, y_max=2, count=3, empty=0.
- Frame with mask all 0 → result_valid_out=1 with empty_out=1, count_out=0, bbox outputs 0.
- Single hit at (7,3) → result x_min=x_max=7, y_min=y_max=3, count=1; confirms the frame-end pixel is included.
- Ready held 0 across two frames (first frame count 3, second frame count 1):
  - Outputs stay stable at the first result until the second frame end.
  - Then they become count=1 and overrun_out=1.
  - Raising ready afterwards drops valid the next cycle; overrun_out stays 1.
- Partial frame with hits at (1,0) followed by a restart at (0,0) with no hits → result shows empty_out=1; the discarded partial frame produces no result.
- rst_n_in pulsed low mid-frame and while result_valid_out=1 → all outputs 0 immediately, without waiting for a clock edge. The next full frame produces a correct, fresh result.
